// File: rtl/rst_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rst_boot_sequencer
// Purpose  : Consumer end of the user-button reset path. A system-reset
//            request produces a fixed-width reset pulse to the user logic
//            tree. A boot request blinks a warning LED for a set time. It then
//            pulses PROGRAMN low to reboot into the bootloader, and parks the
//            design in reset until rst_n is asserted.
//
// Ports    : clk          in   system clock
//            rst_n        in   asynchronous reset, active low
//            sys_rst_req  in   system reset request (synchronous to clk)
//            boot_req     in   bootloader reboot request (synchronous to clk)
//            sys_rst_out  out  reset to user logic, SYS_RESET_LOGIC_LEVEL
//                              when asserted
//            prog_n       out  PROGRAMN drive, active low
//            warn_led     out  reboot warning LED, active high
//            busy         out  high whenever the sequencer is not idle
//
// Options  : RST_SEQ_CANCEL_EN - when defined, releasing boot_req during the
//            warning phase aborts the reboot and returns to idle. When it is
//            undefined, the reboot is committed once the warning starts.
//
// Revision : 1.0 - initial release
// ============================================================================
module rst_boot_sequencer #(
    parameter int CLK_FREQUENCY          = 48000000,
    parameter int SYS_RESET_LOGIC_LEVEL  = 1,
    parameter int BOOT_RESET_LOGIC_LEVEL = 1,
    parameter int SYS_RST_HOLD_CLKS      = 16,
    parameter int BOOT_WARN_MS           = 500,
    parameter int BLINK_HALF_MS          = 50,
    parameter int PROG_PULSE_CLKS        = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sys_rst_req,
    input  logic boot_req,
    output logic sys_rst_out,
    output logic prog_n,
    output logic warn_led,
    output logic busy
);

    // ------------------------------------------------------------------------
    // Derived durations and the shared counter width
    // ------------------------------------------------------------------------
    localparam int c_WARN_CLKS  = CLK_FREQUENCY / 1000 * BOOT_WARN_MS;
    localparam int c_BLINK_CLKS = CLK_FREQUENCY / 1000 * BLINK_HALF_MS;

    localparam int c_MAX_AB  = (c_WARN_CLKS > c_BLINK_CLKS) ? c_WARN_CLKS : c_BLINK_CLKS;
    localparam int c_MAX_CD  = (SYS_RST_HOLD_CLKS > PROG_PULSE_CLKS) ?
                               SYS_RST_HOLD_CLKS : PROG_PULSE_CLKS;
    localparam int c_CNT_MAX = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
    // The extra bit gives headroom so the next blink point
    // (at most WARN_CLKS-1 + BLINK_CLKS) always fits without wrapping.
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SYS_LAST  = c_CNT_W'(SYS_RST_HOLD_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_WARN_LAST = c_CNT_W'(c_WARN_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_PROG_LAST = c_CNT_W'(PROG_PULSE_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_BLINK_STEP = c_CNT_W'(c_BLINK_CLKS);

    localparam logic c_SYS_ACT    = (SYS_RESET_LOGIC_LEVEL != 0);
    localparam logic c_SYS_INACT  = ~c_SYS_ACT;
    localparam logic c_BOOT_ACT   = (BOOT_RESET_LOGIC_LEVEL != 0);
    localparam logic c_BOOT_INACT = ~c_BOOT_ACT;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYS_HOLD = 3'd1,
        ST_WARN     = 3'd2,
        ST_PROG     = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    // Counter value at which warn_led next toggles while in WARN
    logic [c_CNT_W-1:0]   blink_at_q, blink_at_d;
    logic                 sys_prev_q;
    logic                 boot_prev_q;
    logic                 sys_rst_out_q;
    logic                 prog_n_q;
    logic                 warn_led_q;
    logic                 busy_q;

    logic                 sys_edge;
    logic                 boot_edge;
`ifdef RST_SEQ_CANCEL_EN
    logic                 boot_active;
`endif

    // ------------------------------------------------------------------------
    // Request edge detection. The prev registers reset to the inactive
    // level, so a request already asserted at reset release is seen as an
    // edge on the first clock. A held level never re-triggers.
    // ------------------------------------------------------------------------
    always_comb begin
        sys_edge  = (sys_rst_req == c_SYS_ACT)  && (sys_prev_q  != c_SYS_ACT);
        boot_edge = (boot_req    == c_BOOT_ACT) && (boot_prev_q != c_BOOT_ACT);
`ifdef RST_SEQ_CANCEL_EN
        boot_active = (boot_req == c_BOOT_ACT);
`endif
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blink_at_d = blink_at_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // A boot edge wins over a sys edge on the same clock
                if (boot_edge) begin
                    state_d    = ST_WARN;
                    blink_at_d = c_BLINK_STEP;
                end else if (sys_edge) begin
                    state_d = ST_SYS_HOLD;
                end
            end

            ST_SYS_HOLD: begin
                // New sys edges are ignored here, so the hold is never extended
                if (boot_edge) begin
                    state_d    = ST_WARN;
                    cnt_d      = '0;
                    blink_at_d = c_BLINK_STEP;
                end else if (cnt_q == c_SYS_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            ST_WARN: begin
`ifdef RST_SEQ_CANCEL_EN
                if (!boot_active) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else
`endif
                if (cnt_q == c_WARN_LAST) begin
                    state_d = ST_PROG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                    if (cnt_q == blink_at_q) begin
                        blink_at_d = blink_at_q + c_BLINK_STEP;
                    end
                end
            end

            ST_PROG: begin
                if (cnt_q == c_PROG_LAST) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            ST_HALT: begin
                // Terminal: only rst_n leaves this state
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter and registered Moore outputs. The outputs decode the
    // current state register, so they follow the state by one clock. Every
    // dwell time is therefore reproduced exactly on the pins.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            blink_at_q    <= '0;
            sys_prev_q    <= c_SYS_INACT;
            boot_prev_q   <= c_BOOT_INACT;
            sys_rst_out_q <= c_SYS_INACT;
            prog_n_q      <= 1'b1;
            warn_led_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blink_at_q  <= blink_at_d;
            sys_prev_q  <= sys_rst_req;
            boot_prev_q <= boot_req;

            case (state_q)
                ST_IDLE: begin
                    sys_rst_out_q <= c_SYS_INACT;
                    prog_n_q      <= 1'b1;
                    warn_led_q    <= 1'b0;
                    busy_q        <= 1'b0;
                end
                ST_SYS_HOLD: begin
                    sys_rst_out_q <= c_SYS_ACT;
                    prog_n_q      <= 1'b1;
                    warn_led_q    <= 1'b0;
                    busy_q        <= 1'b1;
                end
                ST_WARN: begin
                    sys_rst_out_q <= c_SYS_INACT;
                    prog_n_q      <= 1'b1;
                    busy_q        <= 1'b1;
                    // LED starts lit and flips each time the counter reaches
                    // the next half-period boundary
                    if (cnt_q == '0) begin
                        warn_led_q <= 1'b1;
                    end else if (cnt_q == blink_at_q) begin
                        warn_led_q <= ~warn_led_q;
                    end
                end
                ST_PROG: begin
                    sys_rst_out_q <= c_SYS_ACT;
                    prog_n_q      <= 1'b0;
                    warn_led_q    <= 1'b1;
                    busy_q        <= 1'b1;
                end
                ST_HALT: begin
                    sys_rst_out_q <= c_SYS_ACT;
                    prog_n_q      <= 1'b1;
                    warn_led_q    <= 1'b1;
                    busy_q        <= 1'b1;
                end
                default: begin
                    sys_rst_out_q <= c_SYS_INACT;
                    prog_n_q      <= 1'b1;
                    warn_led_q    <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign sys_rst_out = sys_rst_out_q;
    assign prog_n      = prog_n_q;
    assign warn_led    = warn_led_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_boot_sequencer
// Purpose  : Self-checking bench for rst_boot_sequencer. A schedule-based
//            reference model turns each observed request into a planned list
//            of per-clock output vectors. The expected vectors are queued, and
//            an independent monitor compares them against the DUT pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_boot_sequencer;

    localparam int P_CLK      = 1000;
    localparam int P_WARN_MS  = 10;
    localparam int P_BLINK_MS = 2;
    localparam int P_HOLD     = 4;
    localparam int P_PROG     = 3;
    localparam int WARN_N     = P_CLK / 1000 * P_WARN_MS;   // 10 clocks
    localparam int BLINK_N    = P_CLK / 1000 * P_BLINK_MS;  // 2 clocks

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic sys_rst_req = 1'b0;
    logic boot_req    = 1'b0;
    logic sys_rst_out;
    logic prog_n;
    logic warn_led;
    logic busy;

    rst_boot_sequencer #(
        .CLK_FREQUENCY          (P_CLK),
        .SYS_RESET_LOGIC_LEVEL  (1),
        .BOOT_RESET_LOGIC_LEVEL (1),
        .SYS_RST_HOLD_CLKS      (P_HOLD),
        .BOOT_WARN_MS           (P_WARN_MS),
        .BLINK_HALF_MS          (P_BLINK_MS),
        .PROG_PULSE_CLKS        (P_PROG)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sys_rst_req (sys_rst_req),
        .boot_req    (boot_req),
        .sys_rst_out (sys_rst_out),
        .prog_n      (prog_n),
        .warn_led    (warn_led),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Output vector layout: {sys_rst_out, prog_n, warn_led, busy}
    typedef logic [3:0] outv_t;
    localparam outv_t V_IDLE = 4'b0100;
    localparam outv_t V_SYS  = 4'b1101;
    localparam outv_t V_PROG = 4'b1011;
    localparam outv_t V_HALT = 4'b1111;

    // LED is lit during even-numbered half-periods of the warning phase
    function automatic outv_t v_warn(input int i);
        logic led;
        led = (((i / BLINK_N) % 2) == 0);
        return {1'b0, 1'b1, led, 1'b1};
    endfunction

    typedef enum int {M_IDLE, M_SYS, M_WARN, M_PROG, M_HALT} mtag_t;
    typedef struct {
        outv_t v;
        mtag_t tag;
    } plan_t;

    plan_t  plan[$];
    outv_t  exp_q[$];
    mtag_t  cur_tag = M_IDLE;
    outv_t  prev_z  = V_IDLE;
    logic   pv_sys  = 1'b0;
    logic   pv_boot = 1'b0;
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string name, input outv_t act, input outv_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: {sys_rst_out,prog_n,warn_led,busy} got %b, expected %b",
                     name, $time, act, exp);
        end
    endtask

    task automatic load_warn();
        plan.delete();
        for (int i = 0; i < WARN_N; i++) plan.push_back(plan_t'{v_warn(i), M_WARN});
        for (int i = 0; i < P_PROG; i++) plan.push_back(plan_t'{V_PROG, M_PROG});
    endtask

    task automatic load_sys();
        plan.delete();
        for (int i = 0; i < P_HOLD; i++) plan.push_back(plan_t'{V_SYS, M_SYS});
    endtask

    // Reference model: at each clock, decide the behaviour for the coming
    // clock. That behaviour shows up on the pins one clock later.
    always @(posedge clk) begin : model
        outv_t z;
        logic  se;
        logic  be;
        if (!rst_n) begin
            plan.delete();
            cur_tag = M_IDLE;
            pv_sys  = 1'b0;
            pv_boot = 1'b0;
            prev_z  = V_IDLE;
            exp_q.push_back(V_IDLE);
        end else begin
            exp_q.push_back(prev_z);
            se = sys_rst_req && !pv_sys;
            be = boot_req && !pv_boot;
            case (cur_tag)
                M_IDLE: begin
                    if (be)      load_warn();
                    else if (se) load_sys();
                end
                M_SYS: begin
                    if (be) load_warn();
                end
                M_WARN: begin
`ifdef RST_SEQ_CANCEL_EN
                    if (!boot_req) plan.delete();
`endif
                end
                default: ;
            endcase
            if (plan.size() > 0) begin
                z       = plan[0].v;
                cur_tag = plan[0].tag;
                void'(plan.pop_front());
            end else if (cur_tag == M_PROG || cur_tag == M_HALT) begin
                z       = V_HALT;
                cur_tag = M_HALT;
            end else begin
                z       = V_IDLE;
                cur_tag = M_IDLE;
            end
            prev_z  = z;
            pv_sys  = sys_rst_req;
            pv_boot = boot_req;
        end
    end

    // Monitor: one expected vector per clock, compared mid-cycle
    always @(negedge clk) begin : monitor
        outv_t exp;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard at %0t: no expected entry, got %b", $time,
                     {sys_rst_out, prog_n, warn_led, busy});
        end else begin
            exp = exp_q.pop_front();
            if (!rst_n) exp = V_IDLE;
            check("outputs", {sys_rst_out, prog_n, warn_led, busy}, exp);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic s, input logic b);
        sys_rst_req = s;
        boot_req    = b;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("async_reset", {sys_rst_out, prog_n, warn_led, busy}, V_IDLE);
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        // Idle after reset
        tick(5);
        // Single-clock sys request
        set_in(1'b1, 1'b0); tick(1);
        set_in(1'b0, 1'b0); tick(8);
        // Held boot request through warning, PROGRAMN pulse and halt
        set_in(1'b0, 1'b1); tick(WARN_N + P_PROG + 5);
        set_in(1'b0, 1'b0); pulse_reset(); tick(2);
        // Simultaneous sys and boot edges
        set_in(1'b1, 1'b1); tick(4);
        set_in(1'b0, 1'b0); pulse_reset(); tick(2);
        // Boot edge during the sys hold
        set_in(1'b1, 1'b0); tick(1);
        set_in(1'b0, 1'b0); tick(1);
        set_in(1'b0, 1'b1); tick(6);
        set_in(1'b0, 1'b0); pulse_reset(); tick(2);
        // Reset in the second PROGRAMN clock, boot kept high across release
        set_in(1'b0, 1'b1); tick(WARN_N + 3);
        pulse_reset(); tick(WARN_N + P_PROG + 4);
        set_in(1'b0, 1'b0); pulse_reset(); tick(2);
        // Boot released partway through the warning
        set_in(1'b0, 1'b1); tick(5);
        set_in(1'b0, 1'b0); tick(WARN_N + P_PROG + 4);
        pulse_reset(); tick(2);
        // Randomised requests with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) sys_rst_req = ~sys_rst_req;
            if ($urandom_range(0, 9) == 0) boot_req = ~boot_req;
            if ($urandom_range(0, 59) == 0) pulse_reset();
            else                            tick(1);
        end
        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
